// File: rtl/stack_up_rx_pkg.sv
// Shared definitions for the stack-side upstream receiver: framing codes,
// framing FSM states and the default-width FIFO entry layout.
package stack_up_rx_pkg;

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_OOB_W  = 32;
  localparam int DEF_TYPE_W = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_MSG = 1'b1
  } rx_state_e;

  // Field order matches the flat vector packed into the FIFO by the top level.
  typedef struct packed {
    logic [1:0]            cntl;
    logic [DEF_TYPE_W-1:0] typ;
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_OOB_W-1:0]  oob;
  } rx_entry_t;

endpackage

// File: rtl/stu_rx_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees the head in the same cycle.
module stu_rx_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the top masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/stu_pe_upstream_rx.sv
// Stack-side upstream receiver: registers PE beats, checks message framing,
// buffers legal beats and forwards them to the upstream manager.
module stu_pe_upstream_rx
  import stack_up_rx_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32,
  parameter int TYPE_W = 2,
  parameter int DEPTH  = 8,
  parameter int SKID   = 2
) (
  input  logic              clk,
  input  logic              reset_poweron_n,
  input  logic              pe__stu__valid,
  input  logic [1:0]        pe__stu__cntl,
  input  logic [TYPE_W-1:0] pe__stu__type,
  input  logic [DATA_W-1:0] pe__stu__data,
  input  logic [OOB_W-1:0]  pe__stu__oob_data,
  output logic              stu__pe__ready,
  output logic              stu__mgr__valid,
  output logic [1:0]        stu__mgr__cntl,
  output logic [TYPE_W-1:0] stu__mgr__type,
  output logic [DATA_W-1:0] stu__mgr__data,
  output logic [OOB_W-1:0]  stu__mgr__oob_data,
  input  logic              mgr__stu__ready,
  output logic [15:0]       stu__sys__pkt_count,
  output logic              stu__sys__err_framing,
  output logic              stu__sys__err_overflow,
  input  logic              sys__stu__clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + TYPE_W + DATA_W + OOB_W;

  // Input stage: every beat is registered before framing and FIFO decisions.
  logic              in_valid_q;
  logic [1:0]        in_cntl_q;
  logic [TYPE_W-1:0] in_type_q;
  logic [DATA_W-1:0] in_data_q;
  logic [OOB_W-1:0]  in_oob_q;

  rx_state_e         state_q, state_d;
  logic [OOB_W-1:0]  oob_q;
  logic [15:0]       pkt_q;
  logic              err_frm_q, err_ovf_q, ready_q;

  logic              push, pop, room, accept, overflow;
  logic              latch_oob, frame_err, pkt_inc;
  logic [OOB_W-1:0]  wr_oob;
  logic [EW-1:0]     fifo_wdata, fifo_rdata;
  logic              fifo_empty, fifo_full;
  logic [AW:0]       fifo_count, count_nxt;
  logic              ready_d;

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      in_valid_q <= 1'b0;
      in_cntl_q  <= '0;
      in_type_q  <= '0;
      in_data_q  <= '0;
      in_oob_q   <= '0;
    end else begin
      in_valid_q <= pe__stu__valid;
      in_cntl_q  <= pe__stu__cntl;
      in_type_q  <= pe__stu__type;
      in_data_q  <= pe__stu__data;
      in_oob_q   <= pe__stu__oob_data;
    end
  end

  assign pop      = ~fifo_empty & mgr__stu__ready;
  assign room     = ~fifo_full | pop;
  assign accept   = in_valid_q & room;
  assign overflow = in_valid_q & ~room;

  always_comb begin
    push      = 1'b0;
    state_d   = state_q;
    latch_oob = 1'b0;
    frame_err = 1'b0;
    pkt_inc   = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          case (in_cntl_q)
            CNTL_SOM: begin
              push      = 1'b1;
              latch_oob = 1'b1;
              state_d   = ST_IN_MSG;
            end
            CNTL_SOM_EOM: begin
              push      = 1'b1;
              latch_oob = 1'b1;
              pkt_inc   = 1'b1;
            end
            default: frame_err = 1'b1;
          endcase
        end
        default: begin
          push = 1'b1;
          case (in_cntl_q)
            CNTL_EOM: begin
              state_d = ST_IDLE;
              pkt_inc = 1'b1;
            end
            CNTL_SOM: begin
              latch_oob = 1'b1;
              frame_err = 1'b1;
            end
            CNTL_SOM_EOM: begin
              latch_oob = 1'b1;
              frame_err = 1'b1;
              state_d   = ST_IDLE;
              pkt_inc   = 1'b1;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign wr_oob     = latch_oob ? in_oob_q : oob_q;
  assign fifo_wdata = {in_cntl_q, in_type_q, in_data_q, wr_oob};

  // Ready looks at occupancy after this cycle's push/pop so SKID slots stay free.
  assign count_nxt = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
  assign ready_d   = (DEPTH - int'(count_nxt)) > SKID;

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_q   <= ST_IDLE;
      oob_q     <= '0;
      pkt_q     <= '0;
      err_frm_q <= 1'b0;
      err_ovf_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (latch_oob) oob_q <= in_oob_q;
      if (pkt_inc)   pkt_q <= pkt_q + 16'd1;
      err_frm_q <= (err_frm_q & ~sys__stu__clear_err) | frame_err;
      err_ovf_q <= (err_ovf_q & ~sys__stu__clear_err) | overflow;
      ready_q   <= ready_d;
    end
  end

  stu_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_poweron_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign stu__pe__ready         = ready_q;
  assign stu__mgr__valid        = ~fifo_empty;
  assign stu__mgr__cntl         = fifo_empty ? '0 : fifo_rdata[EW-1 -: 2];
  assign stu__mgr__type         = fifo_empty ? '0 : fifo_rdata[EW-3 -: TYPE_W];
  assign stu__mgr__data         = fifo_empty ? '0 : fifo_rdata[OOB_W +: DATA_W];
  assign stu__mgr__oob_data     = fifo_empty ? '0 : fifo_rdata[OOB_W-1:0];
  assign stu__sys__pkt_count    = pkt_q;
  assign stu__sys__err_framing  = err_frm_q;
  assign stu__sys__err_overflow = err_ovf_q;

endmodule

// File: tb/tb_stu_pe_upstream_rx.sv
// Directed bench for stu_pe_upstream_rx with hand-computed expectations.
module tb_stu_pe_upstream_rx;
  import stack_up_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pv;
  logic [1:0]  pc;
  logic [1:0]  pt;
  logic [63:0] pd;
  logic [31:0] po;
  logic        ready;
  logic        mv;
  logic [1:0]  mc;
  logic [1:0]  mt;
  logic [63:0] md;
  logic [31:0] mo;
  logic        mgr_rdy;
  logic [15:0] pkt;
  logic        e_frm, e_ovf;
  logic        clr;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  stu_pe_upstream_rx dut (
    .clk                    (clk),
    .reset_poweron_n        (rst_n),
    .pe__stu__valid         (pv),
    .pe__stu__cntl          (pc),
    .pe__stu__type          (pt),
    .pe__stu__data          (pd),
    .pe__stu__oob_data      (po),
    .stu__pe__ready         (ready),
    .stu__mgr__valid        (mv),
    .stu__mgr__cntl         (mc),
    .stu__mgr__type         (mt),
    .stu__mgr__data         (md),
    .stu__mgr__oob_data     (mo),
    .mgr__stu__ready        (mgr_rdy),
    .stu__sys__pkt_count    (pkt),
    .stu__sys__err_framing  (e_frm),
    .stu__sys__err_overflow (e_ovf),
    .sys__stu__clear_err    (clr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat at a negedge; returns at the next negedge with valid still high.
  task automatic drive(input logic [1:0] c, input logic [1:0] t, input logic [63:0] d,
                       input logic [31:0] o);
    pv = 1'b1; pc = c; pt = t; pd = d; po = o;
    @(negedge clk);
  endtask

  task automatic idle();
    pv = 1'b0; pc = 2'b00; pd = 64'h0; po = 32'h0;
  endtask

  // Check the FIFO head at a negedge, then let one edge pop it (mgr_rdy=1).
  task automatic expect_head(input string tag, input logic [1:0] c, input logic [63:0] d,
                             input logic [31:0] o);
    check({tag, ".valid"}, 64'(mv), 64'd1);
    check({tag, ".cntl"},  64'(mc), 64'(c));
    check({tag, ".data"},  md, d);
    check({tag, ".oob"},   64'(mo), 64'(o));
    @(negedge clk);
  endtask

  initial begin
    logic r_prev, r_now, fell;
    int   n_sent;

    rst_n = 1'b0; mgr_rdy = 1'b0; clr = 1'b0; pt = 2'b01;
    idle();

    // reset values
    #12;
    check("rst.ready", 64'(ready), 64'd0);
    check("rst.valid", 64'(mv), 64'd0);
    check("rst.data",  md, 64'd0);
    check("rst.pkt",   64'(pkt), 64'd0);
    check("rst.errs",  64'({e_frm, e_ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel.ready0", 64'(ready), 64'd0);
    @(negedge clk);
    check("rel.ready1", 64'(ready), 64'd1);

    // single SOM_EOM: visible two edges after being driven, popped the edge after
    mgr_rdy = 1'b1;
    drive(CNTL_SOM_EOM, 2'b10, 64'h1234, 32'hA5);
    idle();
    check("t1.lat", 64'(mv), 64'd0);
    @(negedge clk);
    check("t1.type", 64'(mt), 64'd2);
    check("t1.pkt", 64'(pkt), 64'd1);
    expect_head("t1", CNTL_SOM_EOM, 64'h1234, 32'hA5);
    check("t1.gone", 64'(mv), 64'd0);
    check("t1.errs", 64'({e_frm, e_ovf}), 64'd0);

    // 4-beat message: every beat carries the SOM tag
    mgr_rdy = 1'b0;
    drive(CNTL_SOM, 2'b01, 64'h10, 32'h7);
    drive(CNTL_MOM, 2'b01, 64'h11, 32'hFF);
    drive(CNTL_MOM, 2'b01, 64'h12, 32'hFF);
    drive(CNTL_EOM, 2'b01, 64'h13, 32'hFF);
    idle();
    @(negedge clk);
    check("t2.pkt", 64'(pkt), 64'd2);
    mgr_rdy = 1'b1;
    expect_head("t2.b0", CNTL_SOM, 64'h10, 32'h7);
    expect_head("t2.b1", CNTL_MOM, 64'h11, 32'h7);
    expect_head("t2.b2", CNTL_MOM, 64'h12, 32'h7);
    expect_head("t2.b3", CNTL_EOM, 64'h13, 32'h7);
    check("t2.gone", 64'(mv), 64'd0);

    // stalled manager, PE honours ready one cycle late
    mgr_rdy = 1'b0; r_prev = 1'b1; fell = 1'b0; n_sent = 0;
    for (int k = 0; k < 20; k++) begin
      r_now = ready;
      if (!r_now) fell = 1'b1;
      if (r_prev) begin
        pv = 1'b1; pc = CNTL_SOM_EOM; pd = 64'h100 + 64'(n_sent); po = 32'h40 + 32'(n_sent);
        n_sent++;
      end else begin
        idle();
      end
      r_prev = r_now;
      @(negedge clk);
    end
    idle();
    check("t3.sent", 64'(n_sent), 64'd8);
    check("t3.fell", 64'(fell), 64'd1);
    check("t3.ready", 64'(ready), 64'd0);
    check("t3.ovf", 64'(e_ovf), 64'd0);
    check("t3.pkt", 64'(pkt), 64'd10);
    mgr_rdy = 1'b1;
    for (int i = 0; i < 8; i++)
      expect_head("t3.drain", CNTL_SOM_EOM, 64'h100 + 64'(i), 32'h40 + 32'(i));
    check("t3.gone", 64'(mv), 64'd0);
    check("t3.ready_up", 64'(ready), 64'd1);

    // PE ignores ready: ninth beat dropped
    mgr_rdy = 1'b0;
    for (int i = 0; i < 9; i++)
      drive(CNTL_SOM_EOM, 2'b01, 64'h200 + 64'(i), 32'h60 + 32'(i));
    idle();
    @(negedge clk);
    @(negedge clk);
    check("t4.ovf", 64'(e_ovf), 64'd1);
    check("t4.frm", 64'(e_frm), 64'd0);
    check("t4.pkt", 64'(pkt), 64'd18);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t4.clr", 64'(e_ovf), 64'd0);
    // push into a full FIFO in the same cycle as a pop
    drive(CNTL_SOM_EOM, 2'b01, 64'h2FF, 32'h7F);
    idle();
    mgr_rdy = 1'b1;
    @(negedge clk);
    check("t4.pp_ovf", 64'(e_ovf), 64'd0);
    check("t4.pp_pkt", 64'(pkt), 64'd19);
    for (int i = 1; i < 8; i++)
      expect_head("t4.drain", CNTL_SOM_EOM, 64'h200 + 64'(i), 32'h60 + 32'(i));
    expect_head("t4.last", CNTL_SOM_EOM, 64'h2FF, 32'h7F);
    check("t4.gone", 64'(mv), 64'd0);

    // framing errors
    drive(CNTL_MOM, 2'b01, 64'h300, 32'h1);
    idle();
    @(negedge clk);
    check("t5.frm", 64'(e_frm), 64'd1);
    check("t5.drop", 64'(mv), 64'd0);
    check("t5.pkt", 64'(pkt), 64'd19);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t5.clr", 64'(e_frm), 64'd0);
    mgr_rdy = 1'b0;
    drive(CNTL_SOM, 2'b01, 64'h31, 32'h11);
    drive(CNTL_SOM, 2'b01, 64'h32, 32'h22);
    drive(CNTL_EOM, 2'b01, 64'h33, 32'h33);
    idle();
    @(negedge clk);
    check("t5.pkt2", 64'(pkt), 64'd20);
    check("t5.frm2", 64'(e_frm), 64'd1);
    mgr_rdy = 1'b1;
    expect_head("t5.b0", CNTL_SOM, 64'h31, 32'h11);
    expect_head("t5.b1", CNTL_SOM, 64'h32, 32'h22);
    expect_head("t5.b2", CNTL_EOM, 64'h33, 32'h22);
    check("t5.gone", 64'(mv), 64'd0);

    // reset mid-message discards the partial message
    mgr_rdy = 1'b0;
    drive(CNTL_SOM, 2'b01, 64'h41, 32'h9);
    drive(CNTL_MOM, 2'b01, 64'h42, 32'h9);
    idle();
    @(negedge clk);
    check("t6.pre", 64'(mv), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6.ready", 64'(ready), 64'd0);
    check("t6.valid", 64'(mv), 64'd0);
    check("t6.fields", 64'({mc, mt, mo}), 64'd0);
    check("t6.data", md, 64'd0);
    check("t6.pkt", 64'(pkt), 64'd0);
    check("t6.errs", 64'({e_frm, e_ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mgr_rdy = 1'b1;
    drive(CNTL_SOM_EOM, 2'b01, 64'hAB, 32'h5);
    idle();
    check("t6.lat", 64'(mv), 64'd0);
    @(negedge clk);
    check("t6.pkt1", 64'(pkt), 64'd1);
    check("t6.frm", 64'(e_frm), 64'd0);
    expect_head("t6", CNTL_SOM_EOM, 64'hAB, 32'h5);
    check("t6.gone", 64'(mv), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stu_pe_upstream_rx.md
# stu_pe_upstream_rx

Stack-side receiver for the upstream stack bus: accepts beats driven by a PE on the `pe__stu__*` signals, applies registered `stu__pe__ready` flow control with a skid margin, and checks message framing. Legal beats are buffered in a FIFO and forwarded to the stack upstream controller over a valid/ready handshake. This block is the responder to the PE-side upstream transmitter and sits between the PE array boundary and the stack upstream manager.

## Interface
Parameters:
- DATA_W, 64, width of `pe__stu__data`
- OOB_W, 32, width of `pe__stu__oob_data`
- TYPE_W, 2, width of `pe__stu__type`
- DEPTH, 8, FIFO entries (power of 2, ≥4)
- SKID, 2, free entries reserved for in-flight beats after ready falls

Ports:
- clk  in  1  single clock
- reset_poweron_n  in  1  asynchronous, active-low reset
- pe__stu__valid  in  1  beat valid
- pe__stu__cntl  in  2  framing: SOM=01, MOM=00, EOM=10, SOM_EOM=11
- pe__stu__type  in  TYPE_W  control/data, vector/scalar
- pe__stu__data  in  DATA_W  payload
- pe__stu__oob_data  in  OOB_W  out-of-band tag, sampled on SOM/SOM_EOM only
- stu__pe__ready  out  1  registered flow control to PE
- stu__mgr__valid  out  1  output beat valid
- stu__mgr__cntl  out  2  framing of output beat
- stu__mgr__type  out  TYPE_W
- stu__mgr__data  out  DATA_W
- stu__mgr__oob_data  out  OOB_W  tag latched at start of the beat's message
- mgr__stu__ready  in  1  downstream accept
- stu__sys__pkt_count  out  16  completed messages accepted (EOM/SOM_EOM written)
- stu__sys__err_framing  out  1  sticky framing error
- stu__sys__err_overflow  out  1  sticky overflow error
- sys__stu__clear_err  in  1  clears sticky errors

## Operation
- Framing FSM, states IDLE and IN_MSG; reset → IDLE.
  - IDLE + SOM → write, latch oob, go IN_MSG. IDLE + SOM_EOM → write, latch oob, stay IDLE, pkt_count++.
  - IDLE + MOM/EOM → drop beat, set err_framing, stay IDLE.
  - IN_MSG + MOM → write. IN_MSG + EOM → write, go IDLE, pkt_count++.
  - IN_MSG + SOM → write as a new message start, latch new oob, set err_framing, stay IN_MSG. IN_MSG + SOM_EOM → write, latch oob, set err_framing, go IDLE, pkt_count++.
- Each FIFO entry stores {cntl, type, data, oob}; the oob field is the latched tag (for SOM beats, the value on the current beat).
- Beats are accepted whenever valid is high and the FIFO is not full. The PE is allowed to send for up to SKID cycles after ready falls.
- Valid with FIFO full → drop beat, set err_overflow; FSM state and pkt_count unchanged.
- pkt_count is 16 bits and wraps 0xFFFF→0.
- Sticky errors hold until sys__stu__clear_err. If clear and a new error occur in the same cycle, the error remains set.
- Output side: the FIFO head drives stu__mgr__*. The head pops when stu__mgr__valid & mgr__stu__ready.

## Timing
- Reset values: stu__pe__ready=0, stu__mgr__valid=0, stu__mgr__cntl/type/data/oob=0, pkt_count=0, both errors=0, FIFO empty, FSM IDLE.
- stu__pe__ready is registered: next = (free entries after this cycle's push/pop) > SKID. It first rises 1 cycle after reset release.
- Write latency: a beat sampled at edge N is visible on stu__mgr__* after edge N+1 when the FIFO was empty. There is no combinational input→output path.
- Simultaneous push and pop with the FIFO full: the pop frees the entry and the push is accepted; no overflow.
- The FIFO count ranges 0..DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- stu__mgr__* is stable while valid is high and ready is low.
- Reset asserted mid-message: all state clears immediately. The partial message is discarded, not flushed.

## Structure
- Shared package `stack_up_rx_pkg`: cntl encodings (SOM/MOM/EOM/SOM_EOM), FSM state enum, FIFO entry struct.
- One sub-module: `stu_rx_fifo`, a synchronous FIFO with count output and async active-low reset. The FSM, ready generation and counters live in the top module.

## Test plan
- Single SOM_EOM beat (data 0x1234, oob 0xA5) into an idle block with mgr__stu__ready=1 → output beat 2 cycles later with identical fields; pkt_count=1; no errors.
- 4-beat message SOM,MOM,MOM,EOM with oob 0x7 on SOM and 0xFF on the others → all 4 output beats carry oob 0x7; pkt_count=1.
- mgr__stu__ready=0 with continuous PE valid (PE honours ready 1 cycle late) → ready falls when free ≤ SKID, exactly DEPTH beats stored, no overflow; release ready → in-order drain.
- PE ignores ready and sends DEPTH+1 beats while the manager is stalled → last beat dropped, err_overflow=1; clear_err → 0.
- MOM in IDLE → beat dropped, err_framing=1. SOM, then SOM, then EOM → 3 beats forwarded, pkt_count +1, err_framing=1.
- Reset asserted after SOM+MOM of a message → all outputs return to reset values; subsequent SOM_EOM yields pkt_count=1 and a single output beat.
